// File: rtl/line_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : line_engine_arbiter
// Function : Round-robin arbiter that shares one line-drawing engine between
//            two command requesters. It latches the winning command, launches
//            the engine, forwards its pixel stream tagged with the owner and
//            guards against a hung engine with a watchdog plus drain phase.
// Revision : 1.0 - initial release
// ============================================================================
module line_engine_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic [1:0] req,
    input  logic [7:0] r0_x0,
    input  logic [7:0] r0_y0,
    input  logic [7:0] r0_x1,
    input  logic [7:0] r0_y1,
    input  logic [7:0] r1_x0,
    input  logic [7:0] r1_y0,
    input  logic [7:0] r1_x1,
    input  logic [7:0] r1_y1,
    output logic [1:0] ack,
    output logic [1:0] cmd_done,
    output logic [1:0] cmd_err,

    output logic       eng_start,
    output logic [7:0] eng_x0,
    output logic [7:0] eng_y0,
    output logic [7:0] eng_x1,
    output logic [7:0] eng_y1,
    input  logic       eng_pixel_valid,
    input  logic [7:0] eng_x,
    input  logic [7:0] eng_y,
    input  logic       eng_busy,
    input  logic       eng_done,

    output logic       pix_valid,
    output logic [7:0] pix_x,
    output logic [7:0] pix_y,
    output logic       pix_owner,
    output logic       arb_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    // Watchdog value seen during the last permitted WAIT cycle.
    localparam logic [CW-1:0] c_wdog_last = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_last_grant;
    logic [CW-1:0] r_wdog;

    logic          w_grant_id;
    logic [7:0]    w_sel_x0;
    logic [7:0]    w_sel_y0;
    logic [7:0]    w_sel_x1;
    logic [7:0]    w_sel_y1;
    logic          w_fwd_window;

    // Pick the winner: a lone requester wins, on contention the one not served last.
    always_comb begin
        w_grant_id = (req == 2'b11) ? ~r_last_grant : req[1];
        w_sel_x0   = w_grant_id ? r1_x0 : r0_x0;
        w_sel_y0   = w_grant_id ? r1_y0 : r0_y0;
        w_sel_x1   = w_grant_id ? r1_x1 : r0_x1;
        w_sel_y1   = w_grant_id ? r1_y1 : r0_y1;
        // Engine pixels belong to the current command only while it is live.
        w_fwd_window = (r_state == S_WAIT) || (r_state == S_LAUNCH);
    end

    // Command FSM: grant, launch, watch for completion or hang, drain a hung engine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wdog       <= '0;
            ack          <= 2'b00;
            cmd_done     <= 2'b00;
            cmd_err      <= 2'b00;
            eng_start    <= 1'b0;
            eng_x0       <= 8'd0;
            eng_y0       <= 8'd0;
            eng_x1       <= 8'd0;
            eng_y1       <= 8'd0;
            arb_busy     <= 1'b0;
        end else begin
            // Status strobes are single-cycle pulses unless re-asserted below.
            ack       <= 2'b00;
            cmd_done  <= 2'b00;
            cmd_err   <= 2'b00;
            eng_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        eng_x0            <= w_sel_x0;
                        eng_y0            <= w_sel_y0;
                        eng_x1            <= w_sel_x1;
                        eng_y1            <= w_sel_y1;
                        r_owner           <= w_grant_id;
                        r_last_grant      <= w_grant_id;
                        ack[w_grant_id]   <= 1'b1;
                        eng_start         <= 1'b1;
                        r_state           <= S_LAUNCH;
                        arb_busy          <= 1'b1;
                    end
                end

                S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_wdog <= r_wdog + CW'(1);
                    // Completion takes priority over a coincident timeout.
                    if (eng_done) begin
                        cmd_done[r_owner] <= 1'b1;
                        r_state           <= S_IDLE;
                        arb_busy          <= 1'b0;
                    end else if (r_wdog == c_wdog_last) begin
                        cmd_err[r_owner]  <= 1'b1;
                        r_state           <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // Late completions are swallowed; wait for a fully quiet engine.
                    if (!eng_busy && !eng_done) begin
                        r_state  <= S_IDLE;
                        arb_busy <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

    // Forward engine pixels with one cycle of latency, tagged with the owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= 8'd0;
            pix_y     <= 8'd0;
            pix_owner <= 1'b0;
        end else begin
            pix_valid <= eng_pixel_valid && w_fwd_window;
            pix_x     <= eng_x;
            pix_y     <= eng_y;
            pix_owner <= r_owner;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_engine_arbiter
// Function : Directed self-checking bench for line_engine_arbiter. The engine
//            is emulated step by step from the stimulus sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_engine_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] r0_x0, r0_y0, r0_x1, r0_y1;
    logic [7:0] r1_x0, r1_y0, r1_x1, r1_y1;
    logic [1:0] ack, cmd_done, cmd_err;
    logic       eng_start;
    logic [7:0] eng_x0, eng_y0, eng_x1, eng_y1;
    logic       eng_pixel_valid;
    logic [7:0] eng_x, eng_y;
    logic       eng_busy, eng_done;
    logic       pix_valid;
    logic [7:0] pix_x, pix_y;
    logic       pix_owner;
    logic       arb_busy;

    int checks   = 0;
    int failures = 0;

    line_engine_arbiter #(
        .TIMEOUT (16),
        .CW      (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .r0_x0           (r0_x0),
        .r0_y0           (r0_y0),
        .r0_x1           (r0_x1),
        .r0_y1           (r0_y1),
        .r1_x0           (r1_x0),
        .r1_y0           (r1_y0),
        .r1_x1           (r1_x1),
        .r1_y1           (r1_y1),
        .ack             (ack),
        .cmd_done        (cmd_done),
        .cmd_err         (cmd_err),
        .eng_start       (eng_start),
        .eng_x0          (eng_x0),
        .eng_y0          (eng_y0),
        .eng_x1          (eng_x1),
        .eng_y1          (eng_y1),
        .eng_pixel_valid (eng_pixel_valid),
        .eng_x           (eng_x),
        .eng_y           (eng_y),
        .eng_busy        (eng_busy),
        .eng_done        (eng_done),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_owner       (pix_owner),
        .arb_busy        (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},       8'(ack),       8'h00);
        check({tag, "_done"},      8'(cmd_done),  8'h00);
        check({tag, "_err"},       8'(cmd_err),   8'h00);
        check({tag, "_start"},     8'(eng_start), 8'h00);
        check({tag, "_x0"},        eng_x0,        8'h00);
        check({tag, "_y0"},        eng_y0,        8'h00);
        check({tag, "_x1"},        eng_x1,        8'h00);
        check({tag, "_y1"},        eng_y1,        8'h00);
        check({tag, "_pvalid"},    8'(pix_valid), 8'h00);
        check({tag, "_px"},        pix_x,         8'h00);
        check({tag, "_py"},        pix_y,         8'h00);
        check({tag, "_powner"},    8'(pix_owner), 8'h00);
        check({tag, "_busy"},      8'(arb_busy),  8'h00);
    endtask

    function automatic logic [7:0] step_to(input logic [7:0] cur, input logic [7:0] dst);
        if (cur < dst) return cur + 8'd1;
        if (cur > dst) return cur - 8'd1;
        return cur;
    endfunction

    // Entered at the negedge of the LAUNCH cycle; returns at the negedge of
    // the cmd_done cycle. Emulates an engine that walks one pixel per cycle.
    task automatic do_line(input logic owner, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1);
        logic [7:0] x;
        logic [7:0] y;
        logic       last;
        tick;
        check("wait_ack_clear",   8'(ack),       8'h00);
        check("wait_start_clear", 8'(eng_start), 8'h00);
        check("wait_busy",        8'(arb_busy),  8'h01);
        x = x0;
        y = y0;
        last = 1'b0;
        for (int n = 0; n < 260 && !last; n++) begin
            eng_busy        = 1'b1;
            eng_pixel_valid = 1'b1;
            eng_x           = x;
            eng_y           = y;
            tick;
            check("pix_valid", 8'(pix_valid), 8'h01);
            check("pix_x",     pix_x,         x);
            check("pix_y",     pix_y,         y);
            check("pix_owner", 8'(pix_owner), 8'(owner));
            last = (x == x1) && (y == y1);
            x = step_to(x, x1);
            y = step_to(y, y1);
        end
        eng_pixel_valid = 1'b0;
        eng_busy        = 1'b0;
        eng_done        = 1'b1;
        tick;
        check("done_pulse",  8'(cmd_done),  owner ? 8'h02 : 8'h01);
        check("done_no_err", 8'(cmd_err),   8'h00);
        check("done_idle",   8'(arb_busy),  8'h00);
        check("done_no_ack", 8'(ack),       8'h00);
        check("done_no_pix", 8'(pix_valid), 8'h00);
        eng_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        r0_x0 = 0; r0_y0 = 0; r0_x1 = 0; r0_y1 = 0;
        r1_x0 = 0; r1_y0 = 0; r1_x1 = 0; r1_y1 = 0;
        eng_pixel_valid = 1'b0;
        eng_x = 0; eng_y = 0;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        tick;
        tick;
        check_all_zero("reset");

        // Single requester 0, horizontal line (2,3)->(5,3).
        rst_n = 1'b1;
        req   = 2'b01;
        r0_x0 = 8'd2; r0_y0 = 8'd3; r0_x1 = 8'd5; r0_y1 = 8'd3;
        tick;
        check("t1_ack",   8'(ack),       8'h01);
        check("t1_start", 8'(eng_start), 8'h01);
        check("t1_busy",  8'(arb_busy),  8'h01);
        check("t1_x0",    eng_x0,        8'd2);
        check("t1_x1",    eng_x1,        8'd5);
        check("t1_y1",    eng_y1,        8'd3);
        req = 2'b00;
        do_line(1'b0, 8'd2, 8'd3, 8'd5, 8'd3);
        tick;
        check("t1_idle_after", 8'(arb_busy), 8'h00);
        check("t1_done_once",  8'(cmd_done), 8'h00);
        check("t1_eng_hold",   eng_x0,       8'd2);

        // Reset, then contention: requester 0 must win first.
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        req   = 2'b11;
        r0_x0 = 8'd0; r0_y0 = 8'd0; r0_x1 = 8'd1; r0_y1 = 8'd1;
        r1_x0 = 8'd9; r1_y0 = 8'd9; r1_x1 = 8'd9; r1_y1 = 8'd9;
        tick;
        check("t2_ack_r0", 8'(ack), 8'h01);
        check("t2_x1",     eng_x1,  8'd1);
        req = 2'b10;
        do_line(1'b0, 8'd0, 8'd0, 8'd1, 8'd1);
        tick;
        check("t2_ack_r1", 8'(ack), 8'h02);
        check("t2_r1_x0",  eng_x0,  8'd9);
        req = 2'b00;
        do_line(1'b1, 8'd9, 8'd9, 8'd9, 8'd9);

        // Continuous contention: grants must alternate 0,1,0,1.
        r0_x0 = 8'd20; r0_y0 = 8'd20; r0_x1 = 8'd21; r0_y1 = 8'd20;
        r1_x0 = 8'd40; r1_y0 = 8'd5;  r1_x1 = 8'd40; r1_y1 = 8'd5;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t3_grant", 8'(ack), (i % 2 == 0) ? 8'h01 : 8'h02);
            check("t3_x0",    eng_x0,  (i % 2 == 0) ? 8'd20 : 8'd40);
            if (i % 2 == 0)
                do_line(1'b0, 8'd20, 8'd20, 8'd21, 8'd20);
            else
                do_line(1'b1, 8'd40, 8'd5, 8'd40, 8'd5);
        end
        req = 2'b00;

        // Hung engine: error after the 16th WAIT cycle, then drain.
        req   = 2'b01;
        r0_x0 = 8'd7; r0_y0 = 8'd8; r0_x1 = 8'd60; r0_y1 = 8'd8;
        tick;
        check("t4_ack", 8'(ack), 8'h01);
        req      = 2'b00;
        eng_busy = 1'b1;
        repeat (16) tick;
        check("t4_no_early_err", 8'(cmd_err),  8'h00);
        check("t4_wait_busy",    8'(arb_busy), 8'h01);
        tick;
        check("t4_err",     8'(cmd_err),  8'h01);
        check("t4_no_done", 8'(cmd_done), 8'h00);
        check("t4_drain",   8'(arb_busy), 8'h01);
        eng_done        = 1'b1;
        eng_pixel_valid = 1'b1;
        eng_x           = 8'd77;
        tick;
        check("t4_err_once",  8'(cmd_err),   8'h00);
        check("t4_late_done", 8'(cmd_done),  8'h00);
        check("t4_drop_pix",  8'(pix_valid), 8'h00);
        check("t4_hold",      8'(arb_busy),  8'h01);
        eng_done        = 1'b0;
        eng_pixel_valid = 1'b0;
        tick;
        check("t4_hold2", 8'(arb_busy), 8'h01);
        eng_busy = 1'b0;
        tick;
        check("t4_back_idle", 8'(arb_busy), 8'h00);
        check("t4_no_done2",  8'(cmd_done), 8'h00);

        // Completion coinciding with the timeout cycle: done wins.
        req   = 2'b10;
        r1_x0 = 8'd1; r1_y0 = 8'd2; r1_x1 = 8'd3; r1_y1 = 8'd4;
        tick;
        check("t5_ack", 8'(ack), 8'h02);
        req      = 2'b00;
        eng_busy = 1'b1;
        repeat (16) tick;
        eng_busy = 1'b0;
        eng_done = 1'b1;
        tick;
        check("t5_done",   8'(cmd_done), 8'h02);
        check("t5_no_err", 8'(cmd_err),  8'h00);
        check("t5_idle",   8'(arb_busy), 8'h00);
        eng_done = 1'b0;
        tick;
        check("t5_no_err2", 8'(cmd_err), 8'h00);

        // Reset in the middle of a line aborts it silently.
        req   = 2'b01;
        r0_x0 = 8'd10; r0_y0 = 8'd10; r0_x1 = 8'd20; r0_y1 = 8'd10;
        tick;
        check("t6_ack", 8'(ack), 8'h01);
        req = 2'b00;
        tick;
        eng_busy        = 1'b1;
        eng_pixel_valid = 1'b1;
        eng_x           = 8'd10;
        eng_y           = 8'd10;
        tick;
        check("t6_pix", 8'(pix_valid), 8'h01);
        rst_n = 1'b0;
        req   = 2'b10;
        r1_x0 = 8'd30; r1_y0 = 8'd31; r1_x1 = 8'd32; r1_y1 = 8'd33;
        eng_x = 8'd11;
        tick;
        check_all_zero("t6_rst");
        rst_n           = 1'b1;
        eng_busy        = 1'b0;
        eng_pixel_valid = 1'b0;
        tick;
        check("t6_ack_r1",  8'(ack),      8'h02);
        check("t6_x0",      eng_x0,       8'd30);
        check("t6_y1",      eng_y1,       8'd33);
        check("t6_no_done", 8'(cmd_done), 8'h00);
        check("t6_no_err",  8'(cmd_err),  8'h00);
        req = 2'b00;
        do_line(1'b1, 8'd30, 8'd31, 8'd32, 8'd33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
